// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin, lockable sharing of the VGA adapter plot port among pixel engines
module vga_plot_arbiter #(
  parameter int NCLIENT = 2,
  parameter int XMAX = 160,
  parameter int YMAX = 120
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCLIENT-1:0]     req,
  input  logic [NCLIENT-1:0]     lock,
  input  logic [8*NCLIENT-1:0]   x_in,
  input  logic [7*NCLIENT-1:0]   y_in,
  input  logic [3*NCLIENT-1:0]   colour_in,
  output logic [NCLIENT-1:0]     ack,
  output logic [7:0]             vga_x,
  output logic [6:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic [1:0]             owner,
  output logic                   locked,
  output logic [15:0]            plot_count
);
  // start is the highest-priority client; kept apart from owner so reset favours client 0
  logic [1:0] start, win, nxt;
  logic any, sel_lock, own_lock, in_range;
  logic [7:0] sx;
  logic [6:0] sy;
  logic [2:0] sc;
  always_comb begin
    any = 1'b0;
    win = owner;
    sx = '0;
    sy = '0;
    sc = '0;
    sel_lock = 1'b0;
    own_lock = 1'b0;
    ack = '0;
    for (int i = 0; i < NCLIENT; i++)
      if (locked && owner == 2'(i) && req[i]) any = 1'b1;
    for (int k = 0; k < NCLIENT; k++)
      for (int i = 0; i < NCLIENT; i++)
        if (!locked && !any && req[i] && (int'(start) + k) % NCLIENT == i) begin
          any = 1'b1;
          win = 2'(i);
        end
    any = any && rst_n;
    for (int i = 0; i < NCLIENT; i++) begin
      if (win == 2'(i)) begin
        sx = x_in[8*i +: 8];
        sy = y_in[7*i +: 7];
        sc = colour_in[3*i +: 3];
        sel_lock = lock[i];
      end
      if (owner == 2'(i)) own_lock = lock[i];
      ack[i] = any && win == 2'(i);
    end
    in_range = int'(sx) < XMAX && int'(sy) < YMAX;
    nxt = win == 2'(NCLIENT - 1) ? 2'd0 : win + 2'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      owner <= '0;
      start <= '0;
      locked <= 1'b0;
      plot_count <= '0;
    end else begin
      vga_plot <= any && in_range;
      locked <= any ? sel_lock : locked && own_lock;
      if (any) begin
        vga_x <= sx;
        vga_y <= sy;
        vga_colour <= sc;
        owner <= win;
        start <= nxt;
      end
      if (any && in_range && plot_count != 16'hFFFF) plot_count <= plot_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed checks of grant order, locking, clipping and async reset
module tb_vga_plot_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req = '0, lock = '0, ack;
  logic [15:0] x_in = '0;
  logic [13:0] y_in = '0;
  logic [5:0] colour_in = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, locked;
  logic [1:0] owner;
  logic [15:0] plot_count;
  int n = 0, f = 0, bad;
  vga_plot_arbiter #(.NCLIENT(2), .XMAX(160), .YMAX(120)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .ack(ack), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .owner(owner), .locked(locked), .plot_count(plot_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      f++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic px(input int c, input int x, input int y, input int col);
    x_in[8*c +: 8] = 8'(x);
    y_in[7*c +: 7] = 7'(y);
    colour_in[3*c +: 3] = 3'(col);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req = '0;
    lock = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  initial begin
    // reset state
    req = 2'b01;
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_owner", owner, 0);
    chk("rst_locked", locked, 0);
    chk("rst_count", plot_count, 0);
    rst_n = 1'b1;
    // single pixel, latency 1
    px(0, 5, 7, 3);
    #1;
    chk("single_ack", ack, 2'b01);
    tick();
    req = '0;
    chk("single_plot", vga_plot, 1);
    chk("single_x", vga_x, 5);
    chk("single_y", vga_y, 7);
    chk("single_col", vga_colour, 3);
    chk("single_count", plot_count, 1);
    tick();
    chk("single_idle_plot", vga_plot, 0);
    chk("single_hold_x", vga_x, 5);
    // round robin between two streaming clients
    do_reset();
    px(0, 10, 1, 1);
    px(1, 20, 2, 2);
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ack", ack, k % 2 == 0 ? 2'b01 : 2'b10);
      tick();
      chk("rr_plot", vga_plot, 1);
      chk("rr_x", vga_x, k % 2 == 0 ? 10 : 20);
      chk("rr_owner", owner, k % 2);
    end
    req = '0;
    chk("rr_count", plot_count, 6);
    // locked full-screen fill by client 0 while client 1 waits
    do_reset();
    px(1, 77, 33, 5);
    req = 2'b11;
    lock = 2'b01;
    bad = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) begin
        px(0, x, y, 2);
        #1;
        if (ack !== 2'b01) bad++;
        tick();
      end
    chk("fill_ack_bad", bad, 0);
    chk("fill_count", plot_count, 19200);
    chk("fill_last_x", vga_x, 159);
    chk("fill_last_y", vga_y, 119);
    chk("fill_locked", locked, 1);
    req = 2'b10;
    lock = 2'b00;
    #1;
    chk("unlock_edge_ack", ack, 2'b00);
    tick();
    chk("unlock_locked", locked, 0);
    chk("unlock_ack1", ack, 2'b10);
    tick();
    chk("unlock_plot1", vga_plot, 1);
    chk("unlock_owner", owner, 1);
    chk("unlock_x", vga_x, 77);
    chk("unlock_count", plot_count, 19201);
    // locked owner idles, client 1 starves
    req = 2'b01;
    lock = 2'b01;
    px(0, 1, 1, 1);
    #1;
    chk("idle_grab_ack", ack, 2'b01);
    tick();
    chk("idle_locked", locked, 1);
    req = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("idle_ack", ack, 2'b00);
      tick();
      chk("idle_plot", vga_plot, 0);
      chk("idle_locked_hold", locked, 1);
    end
    // lock dropped in the same cycle as a grant to the owner
    req = 2'b11;
    lock = 2'b00;
    px(0, 9, 9, 4);
    #1;
    chk("drop_ack", ack, 2'b01);
    tick();
    chk("drop_locked", locked, 0);
    chk("drop_x", vga_x, 9);
    chk("drop_next_ack", ack, 2'b10);
    tick();
    chk("drop_owner", owner, 1);
    req = '0;
    // clipping boundaries
    do_reset();
    req = 2'b01;
    px(0, 160, 0, 1);
    #1;
    chk("clip_ack_a", ack, 2'b01);
    tick();
    chk("clip_plot_a", vga_plot, 0);
    chk("clip_x_a", vga_x, 160);
    px(0, 0, 120, 1);
    #1;
    chk("clip_ack_b", ack, 2'b01);
    tick();
    chk("clip_plot_b", vga_plot, 0);
    px(0, 159, 119, 6);
    #1;
    chk("clip_ack_c", ack, 2'b01);
    tick();
    chk("clip_plot_c", vga_plot, 1);
    chk("clip_count", plot_count, 1);
    // asynchronous reset mid-stream
    px(0, 42, 17, 7);
    px(1, 50, 18, 1);
    req = 2'b11;
    lock = 2'b10;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", ack, 0);
    chk("arst_plot", vga_plot, 0);
    chk("arst_x", vga_x, 0);
    chk("arst_owner", owner, 0);
    chk("arst_locked", locked, 0);
    chk("arst_count", plot_count, 0);
    tick();
    tick();
    tick();
    chk("arst_hold_ack", ack, 0);
    rst_n = 1'b1;
    #1;
    chk("arst_regrant", ack, 2'b01);
    tick();
    chk("arst_x_after", vga_x, 42);
    chk("arst_plot_after", vga_plot, 1);
    chk("arst_owner_after", owner, 0);
    req = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", n, f);
    $finish;
  end
endmodule
